axi_lite_ram_slave: RTL and testbench
=====================================

AXI_LITE_RAM_SLAVE -- requirements
Module: axi_lite_ram_slave

Interface
REQ-001 SHALL have parameter AWIDTH, default 12; meaning: byte-address width of the memory window.
REQ-002 SHALL hold 2^(AWIDTH-2) 32-bit words; word index = addr[AWIDTH-1:2]; addr[1:0] ignored.
REQ-003 SHALL use one clock and synchronous, active-low reset:
  clk  input  1  rising-edge clock
  rstn  input  1  synchronous active-low reset
REQ-004 SHALL expose these AXI4-lite slave ports:
  axi_awvalid  input  1  write-address valid
  axi_awready  output  1  write-address ready
  axi_awaddr  input  32  write byte address
  axi_awprot  input  3  ignored
  axi_wvalid  input  1  write-data valid
  axi_wready  output  1  write-data ready
  axi_wdata  input  32  write data
  axi_wstrb  input  4  byte-lane enables
  axi_bvalid  output  1  write-response valid
  axi_bready  input  1  write-response ready
  axi_bresp  output  2  write response
  axi_arvalid  input  1  read-address valid
  axi_arready  output  1  read-address ready
  axi_araddr  input  32  read byte address
  axi_arprot  input  3  ignored
  axi_rvalid  output  1  read-data valid
  axi_rready  input  1  read-data ready
  axi_rdata  output  32  read data
  axi_rresp  output  2  read response

Function
REQ-005 SHALL treat the write and read channels as independent; both may progress in the same cycle.
REQ-006 Write-address path:
  - axi_awready = !aw_held && !axi_bvalid.
  - On an AW handshake, SHALL latch the address and set aw_held.
REQ-007 Write-data path:
  - axi_wready = !w_held && !axi_bvalid.
  - On a W handshake, SHALL latch data and strobes and set w_held.
  - AW and W may arrive in either order or in the same cycle.
REQ-008 Write commit: at the first edge where aw_held && w_held, SHALL:
  - write the enabled byte lanes only (wstrb[i] selects bits 8i+7:8i);
  - clear aw_held and w_held;
  - set axi_bvalid.
  Latency: both handshakes at edge T -> bvalid high after edge T+1.
REQ-009 axi_bvalid and axi_bresp SHALL stay stable until axi_bready; bvalid clears at the edge where bvalid && bready.
REQ-010 Out-of-range write (awaddr[31:AWIDTH] != 0): SHALL leave memory unmodified and return bresp = SLVERR; otherwise bresp = OKAY.
REQ-011 Read path:
  - axi_arready = !axi_rvalid.
  - AR handshake at edge T -> rvalid high after edge T+1, carrying the word at araddr.
  - rdata and rresp SHALL hold stable until rready; rvalid clears at the rvalid && rready edge.
REQ-012 Out-of-range read: SHALL return rdata = 0 and rresp = SLVERR; otherwise rresp = OKAY.
REQ-013 Same-word read and write at one edge: SHALL be read-before-write; the read returns the old value.
REQ-014 wstrb = 4'b0000: SHALL complete as a normal write with bresp OKAY and leave memory unchanged.

Reset
REQ-015 While rstn = 0 at a clock edge, SHALL clear:
  - axi_bvalid, axi_rvalid, aw_held, w_held = 0;
  - axi_bresp, axi_rresp = 0;
  - axi_rdata = 0.
  Memory contents SHALL NOT be cleared.
REQ-016 Reset mid-transaction SHALL discard any partially latched AW/W and any pending response.
REQ-017 After reset, axi_awready, axi_wready and axi_arready SHALL read 1 on the next cycle.

Structure
REQ-018 Shared package SHALL hold constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
REQ-019 Storage SHALL be a sub-module ram_sdp: simple dual-port, synchronous read, per-byte write enable, parameter AWIDTH-2.

Verification
REQ-020 Write 0xDEADBEEF to 0x010 (wstrb F, AW+W same cycle), then read 0x010 -> bresp OKAY, rdata 0xDEADBEEF, rresp OKAY.
REQ-021 W at cycle 3 and AW at cycle 6 (addr 0x020, data 0x12345678), bready held low 4 cycles:
  - awready/wready low while held;
  - bvalid stable until bready;
  - read 0x020 -> 0x12345678.
REQ-022 Mem[0x030] = 0xAABBCCDD, then write 0x11223344 with wstrb 4'b0101 -> read returns 0xAA22CC44.
REQ-023 Out of range: write 0x1000 -> bresp SLVERR, memory untouched; read 0x1000 -> rdata 0, rresp SLVERR.
REQ-024 Read with rready low 5 cycles -> rdata stable, arready low throughout; back-to-back reads of 0x000 and 0x004 return correct words in order.
REQ-025 Assert rstn = 0 between AW handshake and W -> after reset, no bvalid, previously written words still intact.

Source files
------------

// File: rtl/axi_lite_ram_slave_pkg.sv
// Shared constants and helpers for the AXI4-lite RAM slave.
// Holds the response codes and the address window check.
package axi_lite_ram_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // An address is outside the window when any bit at or above awidth is set.
   function automatic logic addrOutOfRange(input logic [31:0] addr, input int unsigned awidth);
      return (addr >> awidth) != 32'd0;
   endfunction

endpackage

// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-lite bus bundle between a master and the RAM slave.
// The slave modport is used by the design, the master modport by whoever drives it.
interface axi_lite_ram_slave_if;

   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_awaddr;
   logic [2:0]  axi_awprot;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_bvalid;
   logic        axi_bready;
   logic [1:0]  axi_bresp;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_araddr;
   logic [2:0]  axi_arprot;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;

   modport slave (
      input  axi_awvalid, axi_awaddr, axi_awprot,
      input  axi_wvalid, axi_wdata, axi_wstrb,
      input  axi_bready,
      input  axi_arvalid, axi_araddr, axi_arprot,
      input  axi_rready,
      output axi_awready, axi_wready, axi_bvalid, axi_bresp,
      output axi_arready, axi_rvalid, axi_rdata, axi_rresp
   );

   modport master (
      output axi_awvalid, axi_awaddr, axi_awprot,
      output axi_wvalid, axi_wdata, axi_wstrb,
      output axi_bready,
      output axi_arvalid, axi_araddr, axi_arprot,
      output axi_rready,
      input  axi_awready, axi_wready, axi_bvalid, axi_bresp,
      input  axi_arready, axi_rvalid, axi_rdata, axi_rresp
   );

endinterface

// File: rtl/axi_lite_ram_slave_ram_sdp.sv
// Simple dual-port word RAM: one write port with byte enables, one registered read port.
// Read and write to the same word at one edge return the old contents.
module ram_sdp #(
   parameter int WORD_AW = 10
) (
   input  logic               clk_i,
   input  logic               wrEn_i,
   input  logic [WORD_AW-1:0] wrAddr_i,
   input  logic [3:0]         wrByteEn_i,
   input  logic [31:0]        wrData_i,
   input  logic               rdEn_i,
   input  logic [WORD_AW-1:0] rdAddr_i,
   output logic [31:0]        rdData_o
);

   logic [31:0] mem [2**WORD_AW];

   always_ff @(posedge clk_i) begin
      if (rdEn_i) begin
         rdData_o <= mem[rdAddr_i];
      end
      if (wrEn_i) begin
         for (int i = 0; i < 4; i++) begin
            if (wrByteEn_i[i]) begin
               mem[wrAddr_i][8*i +: 8] <= wrData_i[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-lite slave exposing a 2^(AWIDTH-2) word RAM with independent read and write channels.
// AW and W are latched separately and committed together; responses are registered.
module axi_lite_ram_slave
   import axi_lite_ram_slave_pkg::*;
#(
   parameter int AWIDTH = 12
) (
   input  logic                clk,
   input  logic                rstn,
   axi_lite_ram_slave_if.slave bus
);

   localparam int IW = AWIDTH - 2;

   logic          awHeld_q, awHeld_d;
   logic [IW-1:0] awIdx_q, awIdx_d;
   logic          awBad_q, awBad_d;
   logic          wHeld_q, wHeld_d;
   logic [31:0]   wData_q, wData_d;
   logic [3:0]    wStrb_q, wStrb_d;
   logic          bValid_q, bValid_d;
   logic [1:0]    bResp_q, bResp_d;
   logic          rdPend_q, rdPend_d;
   logic          rdBad_q, rdBad_d;
   logic          rValid_q, rValid_d;
   logic [1:0]    rResp_q, rResp_d;
   logic [31:0]   rData_q, rData_d;

   logic          awReady, wReady, arReady;
   logic          awHs, wHs, arHs;
   logic          commit, ramWrEn;
   logic [31:0]   ramRdData;
   logic          unusedBits;

   // The extra rdPend term keeps a second read from being accepted while the RAM lookup is in flight.
   assign awReady = !awHeld_q && !bValid_q;
   assign wReady  = !wHeld_q && !bValid_q;
   assign arReady = !rValid_q && !rdPend_q;

   assign awHs    = bus.axi_awvalid && awReady;
   assign wHs     = bus.axi_wvalid && wReady;
   assign arHs    = bus.axi_arvalid && arReady;
   assign commit  = awHeld_q && wHeld_q;
   assign ramWrEn = commit && !awBad_q;

   assign bus.axi_awready = awReady;
   assign bus.axi_wready  = wReady;
   assign bus.axi_bvalid  = bValid_q;
   assign bus.axi_bresp   = bResp_q;
   assign bus.axi_arready = arReady;
   assign bus.axi_rvalid  = rValid_q;
   assign bus.axi_rdata   = rData_q;
   assign bus.axi_rresp   = rResp_q;

   assign unusedBits = ^{bus.axi_awprot, bus.axi_arprot, bus.axi_awaddr[1:0], bus.axi_araddr[1:0]};

   ram_sdp #(
      .WORD_AW (IW)
   ) u_ram (
      .clk_i      (clk),
      .wrEn_i     (ramWrEn),
      .wrAddr_i   (awIdx_q),
      .wrByteEn_i (wStrb_q),
      .wrData_i   (wData_q),
      .rdEn_i     (arHs),
      .rdAddr_i   (bus.axi_araddr[AWIDTH-1:2]),
      .rdData_o   (ramRdData)
   );

   // Write side: hold AW and W independently, then commit and raise the response once both are in.
   always_comb begin
      awHeld_d = awHeld_q;
      awIdx_d  = awIdx_q;
      awBad_d  = awBad_q;
      wHeld_d  = wHeld_q;
      wData_d  = wData_q;
      wStrb_d  = wStrb_q;
      bValid_d = bValid_q;
      bResp_d  = bResp_q;
      if (bValid_q && bus.axi_bready) begin
         bValid_d = 1'b0;
      end
      if (commit) begin
         awHeld_d = 1'b0;
         wHeld_d  = 1'b0;
         bValid_d = 1'b1;
         bResp_d  = awBad_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (awHs) begin
         awHeld_d = 1'b1;
         awIdx_d  = bus.axi_awaddr[AWIDTH-1:2];
         awBad_d  = addrOutOfRange(bus.axi_awaddr, AWIDTH);
      end
      if (wHs) begin
         wHeld_d = 1'b1;
         wData_d = bus.axi_wdata;
         wStrb_d = bus.axi_wstrb;
      end
   end

   // Read side: the RAM answers one edge after AR, and that word is captured into the held response.
   always_comb begin
      rdPend_d = arHs;
      rdBad_d  = rdBad_q;
      rValid_d = rValid_q;
      rResp_d  = rResp_q;
      rData_d  = rData_q;
      if (arHs) begin
         rdBad_d = addrOutOfRange(bus.axi_araddr, AWIDTH);
      end
      if (rValid_q && bus.axi_rready) begin
         rValid_d = 1'b0;
      end
      if (rdPend_q) begin
         rValid_d = 1'b1;
         rData_d  = rdBad_q ? 32'd0 : ramRdData;
         rResp_d  = rdBad_q ? RESP_SLVERR : RESP_OKAY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         awHeld_q <= 1'b0;
         awIdx_q  <= '0;
         awBad_q  <= 1'b0;
         wHeld_q  <= 1'b0;
         wData_q  <= '0;
         wStrb_q  <= '0;
         bValid_q <= 1'b0;
         bResp_q  <= RESP_OKAY;
         rdPend_q <= 1'b0;
         rdBad_q  <= 1'b0;
         rValid_q <= 1'b0;
         rResp_q  <= RESP_OKAY;
         rData_q  <= '0;
      end else begin
         awHeld_q <= awHeld_d;
         awIdx_q  <= awIdx_d;
         awBad_q  <= awBad_d;
         wHeld_q  <= wHeld_d;
         wData_q  <= wData_d;
         wStrb_q  <= wStrb_d;
         bValid_q <= bValid_d;
         bResp_q  <= bResp_d;
         rdPend_q <= rdPend_d;
         rdBad_q  <= rdBad_d;
         rValid_q <= rValid_d;
         rResp_q  <= rResp_d;
         rData_q  <= rData_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for the AXI4-lite RAM slave: a vector table of single transfers
// plus hand-written sequences for stalls, same-edge read/write and mid-transfer reset.
module tb_axi_lite_ram_slave;

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  expResp;
      logic [31:0] expData;
   } vec_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic clk;
   logic rstn;
   int   total;
   int   bad;
   vec_t vecs[$];

   axi_lite_ram_slave_if bus();

   axi_lite_ram_slave #(
      .AWIDTH (12)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic addVec(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] r, input logic [31:0] e);
      vec_t v;
      v.isWrite = w;
      v.addr    = a;
      v.data    = d;
      v.strb    = s;
      v.expResp = r;
      v.expData = e;
      vecs.push_back(v);
   endtask

   task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit timedOut);
      bit awDone, wDone, awHs, wHs;
      int cyc;
      awDone = 0; wDone = 0; cyc = 0; timedOut = 0;
      @(negedge clk);
      bus.axi_awaddr  = a;
      bus.axi_awvalid = 1'b1;
      bus.axi_wdata   = d;
      bus.axi_wstrb   = s;
      bus.axi_wvalid  = 1'b1;
      bus.axi_bready  = 1'b1;
      while (!(awDone && wDone) && cyc < 50) begin
         awHs = bus.axi_awvalid && bus.axi_awready;
         wHs  = bus.axi_wvalid && bus.axi_wready;
         @(posedge clk); #1;
         if (awHs) begin awDone = 1; bus.axi_awvalid = 1'b0; end
         if (wHs)  begin wDone = 1;  bus.axi_wvalid  = 1'b0; end
         cyc++;
      end
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      while (!bus.axi_bvalid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.axi_bvalid) timedOut = 1;
      resp = bus.axi_bresp;
      @(posedge clk); #1;
      bus.axi_bready = 1'b0;
   endtask

   task automatic doRead(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit timedOut);
      bit hs;
      int cyc;
      hs = 0; cyc = 0; timedOut = 0;
      @(negedge clk);
      bus.axi_araddr  = a;
      bus.axi_arvalid = 1'b1;
      bus.axi_rready  = 1'b1;
      while (!hs && cyc < 50) begin
         hs = bus.axi_arready;
         @(posedge clk); #1;
         cyc++;
      end
      bus.axi_arvalid = 1'b0;
      while (!bus.axi_rvalid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!bus.axi_rvalid) timedOut = 1;
      d    = bus.axi_rdata;
      resp = bus.axi_rresp;
      @(posedge clk); #1;
      bus.axi_rready = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [1:0]  resp;
      logic [31:0] data;
      bit          to;
      if (v.isWrite) begin
         doWrite(v.addr, v.data, v.strb, resp, to);
         checkOutput($sformatf("vec%0d_wr_timeout", idx), 32'(to), 32'd0);
         checkOutput($sformatf("vec%0d_bresp", idx), 32'(resp), 32'(v.expResp));
      end else begin
         doRead(v.addr, data, resp, to);
         checkOutput($sformatf("vec%0d_rd_timeout", idx), 32'(to), 32'd0);
         checkOutput($sformatf("vec%0d_rresp", idx), 32'(resp), 32'(v.expResp));
         checkOutput($sformatf("vec%0d_rdata", idx), data, v.expData);
      end
   endtask

   task automatic readAndCheck(input string name, input logic [31:0] a, input logic [31:0] e);
      logic [1:0]  resp;
      logic [31:0] data;
      bit          to;
      doRead(a, data, resp, to);
      checkOutput({name, "_timeout"}, 32'(to), 32'd0);
      checkOutput({name, "_rresp"}, 32'(resp), 32'(OKAY));
      checkOutput({name, "_rdata"}, data, e);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rstn  = 1'b0;
      bus.axi_awvalid = 1'b0; bus.axi_awaddr = '0; bus.axi_awprot = '0;
      bus.axi_wvalid  = 1'b0; bus.axi_wdata  = '0; bus.axi_wstrb  = '0;
      bus.axi_bready  = 1'b0;
      bus.axi_arvalid = 1'b0; bus.axi_araddr = '0; bus.axi_arprot = '0;
      bus.axi_rready  = 1'b0;

      addVec(1, 32'h000, 32'hCAFEF00D, 4'hF, OKAY,   32'h0);
      addVec(1, 32'h004, 32'h01020304, 4'hF, OKAY,   32'h0);
      addVec(1, 32'h010, 32'hDEADBEEF, 4'hF, OKAY,   32'h0);
      addVec(0, 32'h010, 32'h0,        4'h0, OKAY,   32'hDEADBEEF);
      addVec(1, 32'h030, 32'hAABBCCDD, 4'hF, OKAY,   32'h0);
      addVec(1, 32'h030, 32'h11223344, 4'h5, OKAY,   32'h0);
      addVec(0, 32'h030, 32'h0,        4'h0, OKAY,   32'hAA22CC44);
      addVec(1, 32'h1000, 32'h55555555, 4'hF, SLVERR, 32'h0);
      addVec(0, 32'h1000, 32'h0,        4'h0, SLVERR, 32'h0);
      addVec(0, 32'h000, 32'h0,        4'h0, OKAY,   32'hCAFEF00D);
      addVec(0, 32'h004, 32'h0,        4'h0, OKAY,   32'h01020304);
      addVec(1, 32'h030, 32'hFFFFFFFF, 4'h0, OKAY,   32'h0);
      addVec(0, 32'h030, 32'h0,        4'h0, OKAY,   32'hAA22CC44);
      addVec(1, 32'h013, 32'h0BADC0DE, 4'h3, OKAY,   32'h0);
      addVec(0, 32'h010, 32'h0,        4'h0, OKAY,   32'hDEADC0DE);
      addVec(1, 32'hFFFFF040, 32'h77777777, 4'hF, SLVERR, 32'h0);
      addVec(1, 32'h040, 32'h11111111, 4'hF, OKAY,   32'h0);
      addVec(0, 32'h040, 32'h0,        4'h0, OKAY,   32'h11111111);

      // Reset state and ready-after-reset
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
      checkOutput("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
      checkOutput("rst_bresp",  32'(bus.axi_bresp),  32'd0);
      checkOutput("rst_rresp",  32'(bus.axi_rresp),  32'd0);
      checkOutput("rst_rdata",  bus.axi_rdata,       32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_awready", 32'(bus.axi_awready), 32'd1);
      checkOutput("rst_wready",  32'(bus.axi_wready),  32'd1);
      checkOutput("rst_arready", 32'(bus.axi_arready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
      end

      // W first, AW three cycles later, then a stalled write response
      @(negedge clk);
      bus.axi_wdata = 32'h12345678; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
      bus.axi_bready = 1'b0;
      @(posedge clk); #1;
      bus.axi_wvalid = 1'b0;
      checkOutput("split_wready_held", 32'(bus.axi_wready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("split_wait%0d_wready", i), 32'(bus.axi_wready), 32'd0);
         checkOutput($sformatf("split_wait%0d_bvalid", i), 32'(bus.axi_bvalid), 32'd0);
      end
      checkOutput("split_awready_free", 32'(bus.axi_awready), 32'd1);
      bus.axi_awaddr = 32'h020; bus.axi_awvalid = 1'b1;
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      checkOutput("split_awready_held", 32'(bus.axi_awready), 32'd0);
      checkOutput("split_bvalid_early", 32'(bus.axi_bvalid),  32'd0);
      @(posedge clk); #1;
      checkOutput("split_bvalid_lat", 32'(bus.axi_bvalid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("split_stall%0d_bvalid", i),  32'(bus.axi_bvalid),  32'd1);
         checkOutput($sformatf("split_stall%0d_bresp", i),   32'(bus.axi_bresp),   32'(OKAY));
         checkOutput($sformatf("split_stall%0d_awready", i), 32'(bus.axi_awready), 32'd0);
         checkOutput($sformatf("split_stall%0d_wready", i),  32'(bus.axi_wready),  32'd0);
      end
      bus.axi_bready = 1'b1;
      @(posedge clk); #1;
      bus.axi_bready = 1'b0;
      checkOutput("split_bvalid_clear", 32'(bus.axi_bvalid), 32'd0);
      readAndCheck("split_read", 32'h020, 32'h12345678);

      // Read held by rready low for five cycles
      @(negedge clk);
      bus.axi_araddr = 32'h000; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b0;
      @(posedge clk); #1;
      bus.axi_arvalid = 1'b0;
      checkOutput("rstall_rvalid_early", 32'(bus.axi_rvalid), 32'd0);
      @(posedge clk); #1;
      checkOutput("rstall_rvalid_lat", 32'(bus.axi_rvalid), 32'd1);
      checkOutput("rstall_rdata_lat",  bus.axi_rdata,       32'hCAFEF00D);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("rstall%0d_rvalid", i),  32'(bus.axi_rvalid),  32'd1);
         checkOutput($sformatf("rstall%0d_rdata", i),   bus.axi_rdata,        32'hCAFEF00D);
         checkOutput($sformatf("rstall%0d_arready", i), 32'(bus.axi_arready), 32'd0);
      end
      bus.axi_rready = 1'b1;
      @(posedge clk); #1;
      bus.axi_rready = 1'b0;
      checkOutput("rstall_rvalid_clear",  32'(bus.axi_rvalid),  32'd0);
      checkOutput("rstall_arready_again", 32'(bus.axi_arready), 32'd1);
      readAndCheck("b2b_rd0", 32'h000, 32'hCAFEF00D);
      readAndCheck("b2b_rd4", 32'h004, 32'h01020304);

      // Read of a word at the same edge it is being committed sees the old value
      @(negedge clk);
      bus.axi_awaddr = 32'h040; bus.axi_awvalid = 1'b1;
      bus.axi_wdata = 32'h22222222; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
      bus.axi_bready = 1'b0;
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
      bus.axi_araddr = 32'h040; bus.axi_arvalid = 1'b1; bus.axi_rready = 1'b1;
      @(posedge clk); #1;
      bus.axi_arvalid = 1'b0;
      checkOutput("rbw_bvalid", 32'(bus.axi_bvalid), 32'd1);
      @(posedge clk); #1;
      checkOutput("rbw_rvalid", 32'(bus.axi_rvalid), 32'd1);
      checkOutput("rbw_rdata_old", bus.axi_rdata, 32'h11111111);
      bus.axi_bready = 1'b1;
      @(posedge clk); #1;
      bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;
      checkOutput("rbw_bvalid_clear", 32'(bus.axi_bvalid), 32'd0);
      checkOutput("rbw_rvalid_clear", 32'(bus.axi_rvalid), 32'd0);
      readAndCheck("rbw_read_new", 32'h040, 32'h22222222);

      // Reset drops a pending write response
      @(negedge clk);
      bus.axi_awaddr = 32'h008; bus.axi_awvalid = 1'b1;
      bus.axi_wdata = 32'h99999999; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
      bus.axi_bready = 1'b0;
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
      @(posedge clk); #1;
      checkOutput("rstb_bvalid_before", 32'(bus.axi_bvalid), 32'd1);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      checkOutput("rstb_bvalid_after", 32'(bus.axi_bvalid), 32'd0);

      // Reset between an AW handshake and its W discards the held address
      @(negedge clk);
      bus.axi_awaddr = 32'h010; bus.axi_awvalid = 1'b1;
      @(posedge clk); #1;
      bus.axi_awvalid = 1'b0;
      checkOutput("rstaw_awready_held", 32'(bus.axi_awready), 32'd0);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      checkOutput("rstaw_awready", 32'(bus.axi_awready), 32'd1);
      checkOutput("rstaw_wready",  32'(bus.axi_wready),  32'd1);
      checkOutput("rstaw_arready", 32'(bus.axi_arready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("rstaw_bvalid%0d", i), 32'(bus.axi_bvalid), 32'd0);
      end
      readAndCheck("rstaw_keep010", 32'h010, 32'hDEADC0DE);
      readAndCheck("rstaw_keep000", 32'h000, 32'hCAFEF00D);
      readAndCheck("rstaw_keep008", 32'h008, 32'h99999999);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
